if_stats: RTL and testbench

Front-end sample conditioner and IF statistics counter, sitting directly upstream of the sampler and demodulator bank. It synchronises the two asynchronous limiter comparator inputs into registered `sample_high` and `sample_low` bits, which feed the samplers and demodulators. Over a programmable window it counts how many samples had the magnitude bit set and how many had the sign bit set. At the end of each window it latches both counts and raises a service request, so the CPU can judge signal level and bias and adjust the 3-bit threshold DAC.

---
 rtl/if_stats.sv | 114 +++++++++++
 tb/tb_if_stats.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stats.sv
// IF sample conditioner: synchronises the limiter comparators and counts
// magnitude/sign hits over a programmable window, latching results for the CPU.
module if_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             limiter_high,
  input  logic             limiter_low,
  output logic             sample_high,
  output logic             sample_low,
  input  logic             wr,
  input  logic [CNT_W-1:0] din,
  input  logic             rd,
  output logic [CNT_W-1:0] mag_cnt,
  output logic [CNT_W-1:0] sign_cnt,
  output logic             srq,
  output logic             overrun
);

  logic             r_sync_high;
  logic             r_sync_low;
  logic             r_sample_high;
  logic             r_sample_low;
  logic [CNT_W-1:0] r_win_len;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W:0]   r_acc_mag;
  logic [CNT_W:0]   r_acc_sign;
  logic [CNT_W-1:0] r_mag_cnt;
  logic [CNT_W-1:0] r_sign_cnt;
  logic             r_srq;
  logic             r_overrun;

  logic             w_done;
  logic [CNT_W:0]   w_mag_sum;
  logic [CNT_W:0]   w_sign_sum;

  // A full 2^CNT_W window of ones needs the extra accumulator bit; clamp it.
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] v);
    sat = v[CNT_W] ? {CNT_W{1'b1}} : v[CNT_W-1:0];
  endfunction

  assign w_done     = (r_win_cnt == '0) && !wr;
  assign w_mag_sum  = r_acc_mag  + {{CNT_W{1'b0}}, r_sample_low};
  assign w_sign_sum = r_acc_sign + {{CNT_W{1'b0}}, r_sample_high};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync_high   <= 1'b0;
      r_sync_low    <= 1'b0;
      r_sample_high <= 1'b0;
      r_sample_low  <= 1'b0;
    end else begin
      r_sync_high   <= limiter_high;
      r_sync_low    <= limiter_low;
      r_sample_high <= r_sync_high;
      r_sample_low  <= r_sync_low;
    end
  end

  // A write restarts the window and drops the sample present this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win_len  <= {CNT_W{1'b1}};
      r_win_cnt  <= {CNT_W{1'b1}};
      r_acc_mag  <= '0;
      r_acc_sign <= '0;
    end else if (wr) begin
      r_win_len  <= din;
      r_win_cnt  <= din;
      r_acc_mag  <= '0;
      r_acc_sign <= '0;
    end else if (w_done) begin
      r_win_cnt  <= r_win_len;
      r_acc_mag  <= '0;
      r_acc_sign <= '0;
    end else begin
      r_win_cnt  <= r_win_cnt - 1'b1;
      r_acc_mag  <= w_mag_sum;
      r_acc_sign <= w_sign_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mag_cnt  <= '0;
      r_sign_cnt <= '0;
      r_srq      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_done) begin
        r_mag_cnt  <= sat(w_mag_sum);
        r_sign_cnt <= sat(w_sign_sum);
      end
      if (w_done)
        r_srq <= 1'b1;
      else if (rd)
        r_srq <= 1'b0;
      // An acknowledge clears overrun even when a new result lands with it.
      if (rd)
        r_overrun <= 1'b0;
      else if (w_done && r_srq)
        r_overrun <= 1'b1;
    end
  end

  assign sample_high = r_sample_high;
  assign sample_low  = r_sample_low;
  assign mag_cnt     = r_mag_cnt;
  assign sign_cnt    = r_sign_cnt;
  assign srq         = r_srq;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_if_stats.sv
// Directed + randomised bench for if_stats with a window-list reference model,
// run at a reduced counter width so default windows stay short.
module tb_if_stats;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         limiter_high;
  logic         limiter_low;
  logic         sample_high;
  logic         sample_low;
  logic         wr;
  logic [W-1:0] din;
  logic         rd;
  logic [W-1:0] mag_cnt;
  logic [W-1:0] sign_cnt;
  logic         srq;
  logic         overrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_stats #(.CNT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .limiter_high (limiter_high),
    .limiter_low  (limiter_low),
    .sample_high  (sample_high),
    .sample_low   (sample_low),
    .wr           (wr),
    .din          (din),
    .rd           (rd),
    .mag_cnt      (mag_cnt),
    .sign_cnt     (sign_cnt),
    .srq          (srq),
    .overrun      (overrun)
  );

  // Reference model: {high,low} pairs; pipe front is the visible sample,
  // win holds the samples collected in the open window.
  logic [1:0]   m_pipe[$];
  logic [1:0]   m_win[$];
  int           m_len;
  logic [W-1:0] m_mag;
  logic [W-1:0] m_sign;
  logic         m_srq;
  logic         m_ovr;

  task automatic model_reset();
    m_pipe.delete();
    m_pipe.push_back(2'b00);
    m_pipe.push_back(2'b00);
    m_win.delete();
    m_len  = 1 << W;
    m_mag  = '0;
    m_sign = '0;
    m_srq  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_edge(input logic rst_v, input logic hi, input logic lo,
                            input logic wr_v, input logic [W-1:0] din_v,
                            input logic rd_v);
    logic [1:0] cur;
    bit         done;
    int         nm;
    int         ns;
    if (!rst_v) begin
      model_reset();
    end else begin
      cur  = m_pipe[0];
      done = 0;
      if (wr_v) begin
        m_len = int'(din_v) + 1;
        m_win.delete();
      end else begin
        m_win.push_back(cur);
        if (m_win.size() == m_len) begin
          done = 1;
          nm = 0;
          ns = 0;
          foreach (m_win[i]) begin
            nm += int'(m_win[i][0]);
            ns += int'(m_win[i][1]);
          end
          m_mag  = W'((nm > MAXV) ? MAXV : nm);
          m_sign = W'((ns > MAXV) ? MAXV : ns);
          m_win.delete();
        end
      end
      if (rd_v) m_ovr = 1'b0;
      else if (done && m_srq) m_ovr = 1'b1;
      if (done) m_srq = 1'b1;
      else if (rd_v) m_srq = 1'b0;
      void'(m_pipe.pop_front());
      m_pipe.push_back({hi, lo});
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rst, limiter_high, limiter_low, wr, din, rd);
    #1;
    check("sample_high", 32'(sample_high), 32'(m_pipe[0][1]));
    check("sample_low",  32'(sample_low),  32'(m_pipe[0][0]));
    check("mag_cnt",     32'(mag_cnt),     32'(m_mag));
    check("sign_cnt",    32'(sign_cnt),    32'(m_sign));
    check("srq",         32'(srq),         32'(m_srq));
    check("overrun",     32'(overrun),     32'(m_ovr));
  endtask

  task automatic rand_inputs();
    limiter_high = 1'($urandom_range(0, 1));
    limiter_low  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b0; limiter_high = 1'b0; limiter_low = 1'b0;
    wr = 1'b0; rd = 1'b0; din = '0;
    model_reset();

    // Reset state
    step(); step();
    check("rst_srq", 32'(srq), 32'd0);
    check("rst_mag", 32'(mag_cnt), 32'd0);
    rst = 1'b1;

    // Basic magnitude count, window of 4
    limiter_low = 1'b1;
    step(); step(); step();
    wr = 1'b1; din = 8'd3; step(); wr = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("basic_mag", 32'(mag_cnt), 32'd4);
    check("basic_sign", 32'(sign_cnt), 32'd0);

    // Sign count, window of 8 with toggling sign
    limiter_low = 1'b0;
    wr = 1'b1; din = 8'd7; step(); wr = 1'b0;
    for (int i = 0; i < 24; i++) begin
      limiter_high = ~limiter_high;
      step();
    end
    check("sign_sign", 32'(sign_cnt), 32'd4);
    check("sign_mag", 32'(mag_cnt), 32'd0);

    // Overrun across two completions, then acknowledge
    rd = 1'b0;
    step();
    if (srq) begin rd = 1'b1; step(); rd = 1'b0; end
    wr = 1'b1; din = 8'd1; step(); wr = 1'b0;
    for (int i = 0; i < 6; i++) begin rand_inputs(); step(); end
    check("ovr_set", 32'(overrun), 32'd1);
    rd = 1'b1; step();
    check("ack_srq", 32'(srq), 32'd0);
    check("ack_ovr", 32'(overrun), 32'd0);

    // rd on a completion cycle keeps srq
    step(); rd = 1'b0;
    check("rd_coll_srq", 32'(srq), 32'd1);
    check("rd_coll_ovr", 32'(overrun), 32'd0);

    // wr on the win_cnt==0 cycle suppresses completion
    rd = 1'b1; step(); rd = 1'b0;
    wr = 1'b1; din = 8'd5; step(); wr = 1'b0;
    check("wr_coll_srq", 32'(srq), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rand_inputs(); step();
      check("wr_coll_quiet", 32'(srq), 32'd0);
    end
    step();
    check("wr_coll_next", 32'(srq), 32'd1);

    // Randomised traffic with short windows including length 1
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      wr  = ($urandom_range(0, 19) == 0);
      din = W'($urandom_range(0, 5));
      rd  = ($urandom_range(0, 3) == 0);
      step();
    end
    wr = 1'b0; rd = 1'b0;

    // Saturation on the default 2^W window
    rst = 1'b0; step(); rst = 1'b1;
    limiter_high = 1'b1; limiter_low = 1'b1;
    for (int i = 0; i < 2 * (1 << W); i++) step();
    check("sat_mag", 32'(mag_cnt), 32'(MAXV));
    check("sat_sign", 32'(sign_cnt), 32'(MAXV));
    check("sat_srq", 32'(srq), 32'd1);

    // Reset mid-window
    wr = 1'b1; din = 8'd9; step(); wr = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_inputs(); step(); end
    rst = 1'b0; step(); rst = 1'b1;
    check("mid_rst_mag", 32'(mag_cnt), 32'd0);
    check("mid_rst_sign", 32'(sign_cnt), 32'd0);
    check("mid_rst_srq", 32'(srq), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    check("mid_rst_sh", 32'(sample_high), 32'd0);
    check("mid_rst_sl", 32'(sample_low), 32'd0);
    for (int i = 0; i < (1 << W) - 1; i++) begin
      rand_inputs(); step();
      check("mid_rst_quiet", 32'(srq), 32'd0);
    end
    step();
    check("mid_rst_first", 32'(srq), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
